// File: rtl/timer_regs_pkg.sv
// Shared register map, CTRL/STATUS bit positions and bus FSM encoding for the timer register block.
package timer_regs_pkg;

   localparam logic [2:0] ADDR_CTRL   = 3'd0;
   localparam logic [2:0] ADDR_TERM   = 3'd1;
   localparam logic [2:0] ADDR_STATUS = 3'd2;
   localparam logic [2:0] ADDR_COUNT  = 3'd3;

   localparam int CTRL_MODE   = 0;
   localparam int CTRL_IRQ_EN = 1;
   localparam int CTRL_START  = 8;
   localparam int CTRL_HALT   = 9;

   localparam int STAT_STATUS  = 0;
   localparam int STAT_PENDING = 1;
   localparam int STAT_OVERRUN = 2;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ACK  = 2'd1,
      ST_WAIT = 2'd2
   } bus_state_t;

endpackage

// File: rtl/timer_irq_latch.sv
// Timer interrupt latch: pending/overrun flags with set-over-clear priority and the gated irq level.
module timer_irq_latch (
   input  logic clk,
   input  logic i_reset,
   input  logic i_rf_int,
   input  logic i_clr_pending,
   input  logic i_clr_overrun,
   input  logic i_irq_en,
   output logic o_pending,
   output logic o_overrun,
   output logic o_irq
);

   logic r_pending;
   logic r_overrun;

   always_ff @(posedge clk) begin
      if (i_reset) begin
         r_pending <= 1'b0;
         r_overrun <= 1'b0;
      end else begin
         if (i_rf_int)
            r_pending <= 1'b1;
         else if (i_clr_pending)
            r_pending <= 1'b0;

         // An event landing on an already-pending flag is lost unless software is acking it now.
         if (i_rf_int && r_pending && !i_clr_pending)
            r_overrun <= 1'b1;
         else if (i_clr_overrun)
            r_overrun <= 1'b0;
      end
   end

   assign o_pending = r_pending;
   assign o_overrun = r_overrun;
   assign o_irq     = r_pending & i_irq_en;

endmodule

// File: rtl/timer_regs.sv
// Timer register file: req/ack bus FSM, CTRL/TERM/STATUS/COUNT decode, trigger pulses.
// state | meaning
// IDLE  | waiting for bus_req; access sampled on the edge that leaves IDLE
// ACK   | bus_ack=1 and bus_rdata valid for this single cycle
// WAIT  | access done, waiting for bus_req to drop
module timer_regs
   import timer_regs_pkg::*;
#(
   parameter logic [31:0] RESET_TERM = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        bus_req,
   input  logic        bus_we,
   input  logic [2:0]  bus_addr,
   input  logic [31:0] bus_wdata,
   output logic [31:0] bus_rdata,
   output logic        bus_ack,
   output logic        ro_trig_start,
   output logic        ro_trig_halt,
   output logic        ro_mode,
   output logic [31:0] ro_termcount,
   input  logic        rf_status,
   input  logic [31:0] rf_currcount,
   input  logic        rf_int,
   output logic        irq
);

   bus_state_t  r_state;
   logic        r_ack;
   logic [31:0] r_rdata;
   logic [31:0] r_term;
   logic        r_mode;
   logic        r_irq_en;
   logic        r_trig_start;
   logic        r_trig_halt;

   logic        w_sample;
   logic        w_wr_status;
   logic        w_pending;
   logic        w_overrun;
   logic [31:0] w_rd_mux;

   assign w_sample    = (r_state == ST_IDLE) && bus_req;
   assign w_wr_status = w_sample && bus_we && (bus_addr == ADDR_STATUS);

   always_comb begin
      w_rd_mux = 32'h0;
      case (bus_addr)
         ADDR_CTRL: begin
            w_rd_mux[CTRL_MODE]   = r_mode;
            w_rd_mux[CTRL_IRQ_EN] = r_irq_en;
         end
         ADDR_TERM:  w_rd_mux = r_term;
         ADDR_STATUS: begin
            w_rd_mux[STAT_STATUS]  = rf_status;
            w_rd_mux[STAT_PENDING] = w_pending;
            w_rd_mux[STAT_OVERRUN] = w_overrun;
         end
         ADDR_COUNT: w_rd_mux = rf_currcount;
         default:    w_rd_mux = 32'h0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state      <= ST_IDLE;
         r_ack        <= 1'b0;
         r_rdata      <= 32'h0;
         r_term       <= RESET_TERM;
         r_mode       <= 1'b0;
         r_irq_en     <= 1'b0;
         r_trig_start <= 1'b0;
         r_trig_halt  <= 1'b0;
      end else begin
         r_ack        <= 1'b0;
         r_rdata      <= 32'h0;
         r_trig_start <= 1'b0;
         r_trig_halt  <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (bus_req) begin
                  r_state <= ST_ACK;
                  r_ack   <= 1'b1;
                  if (!bus_we) begin
                     r_rdata <= w_rd_mux;
                  end else if (bus_addr == ADDR_CTRL) begin
                     r_mode       <= bus_wdata[CTRL_MODE];
                     r_irq_en     <= bus_wdata[CTRL_IRQ_EN];
                     // Halt wins when both trigger bits are written together.
                     r_trig_start <= bus_wdata[CTRL_START] & ~bus_wdata[CTRL_HALT];
                     r_trig_halt  <= bus_wdata[CTRL_HALT];
                  end else if (bus_addr == ADDR_TERM) begin
                     r_term <= bus_wdata;
                  end
               end
            end
            ST_ACK:  r_state <= bus_req ? ST_WAIT : ST_IDLE;
            ST_WAIT: if (!bus_req) r_state <= ST_IDLE;
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   timer_irq_latch u_irq_latch (
      .clk           (clk),
      .i_reset       (reset),
      .i_rf_int      (rf_int),
      .i_clr_pending (w_wr_status && bus_wdata[STAT_PENDING]),
      .i_clr_overrun (w_wr_status && bus_wdata[STAT_OVERRUN]),
      .i_irq_en      (r_irq_en),
      .o_pending     (w_pending),
      .o_overrun     (w_overrun),
      .o_irq         (irq)
   );

   assign bus_ack       = r_ack;
   assign bus_rdata     = r_rdata;
   assign ro_trig_start = r_trig_start;
   assign ro_trig_halt  = r_trig_halt;
   assign ro_mode       = r_mode;
   assign ro_termcount  = r_term;

endmodule

// File: tb/tb_timer_regs.sv
// Bench for timer_regs: directed register-map scenarios plus random accesses against a transaction-level model.
module tb_timer_regs;

   localparam logic [31:0] RST_TERM = 32'hDEAD_0007;

   logic        clk = 1'b0;
   logic        reset;
   logic        bus_req;
   logic        bus_we;
   logic [2:0]  bus_addr;
   logic [31:0] bus_wdata;
   logic [31:0] bus_rdata;
   logic        bus_ack;
   logic        ro_trig_start;
   logic        ro_trig_halt;
   logic        ro_mode;
   logic [31:0] ro_termcount;
   logic        rf_status;
   logic [31:0] rf_currcount;
   logic        rf_int;
   logic        irq;

   int n_checks = 0;
   int n_fail   = 0;

   // reference model of the architectural register state
   bit          m_mode, m_irq_en, m_pend, m_ovr;
   logic [31:0] m_term;
   logic [31:0] obs_rd;

   always #5 clk = ~clk;

   timer_regs #(.RESET_TERM(RST_TERM)) dut (
      .clk           (clk),
      .reset         (reset),
      .bus_req       (bus_req),
      .bus_we        (bus_we),
      .bus_addr      (bus_addr),
      .bus_wdata     (bus_wdata),
      .bus_rdata     (bus_rdata),
      .bus_ack       (bus_ack),
      .ro_trig_start (ro_trig_start),
      .ro_trig_halt  (ro_trig_halt),
      .ro_mode       (ro_mode),
      .ro_termcount  (ro_termcount),
      .rf_status     (rf_status),
      .rf_currcount  (rf_currcount),
      .rf_int        (rf_int),
      .irq           (irq)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [31:0] model_read(input logic [2:0] a);
      case (a)
         3'd0:    return {30'h0, m_irq_en, m_mode};
         3'd1:    return m_term;
         3'd2:    return {29'h0, m_ovr, m_pend, rf_status};
         3'd3:    return rf_currcount;
         default: return 32'h0;
      endcase
   endfunction

   // One clock: samp says whether this edge is the bench's intended sampling edge.
   task automatic step(input bit samp, input bit rst, input bit intr);
      logic [31:0] e_rd;
      bit e_ack, e_st, e_ht, clr_p, clr_o, set_o;
      reset        = rst;
      rf_int       = intr;
      rf_status    = 1'($urandom_range(0, 1));
      rf_currcount = $urandom;
      e_rd = 32'h0; e_ack = 0; e_st = 0; e_ht = 0;
      if (rst) begin
         m_mode = 0; m_irq_en = 0; m_pend = 0; m_ovr = 0; m_term = RST_TERM;
      end else begin
         clr_p = samp && bus_we && bus_addr == 3'd2 && bus_wdata[1];
         clr_o = samp && bus_we && bus_addr == 3'd2 && bus_wdata[2];
         if (samp) begin
            e_ack = 1;
            if (!bus_we) e_rd = model_read(bus_addr);
            else if (bus_addr == 3'd0) begin
               m_mode   = bus_wdata[0];
               m_irq_en = bus_wdata[1];
               e_ht     = bus_wdata[9];
               e_st     = bus_wdata[8] && !bus_wdata[9];
            end else if (bus_addr == 3'd1) m_term = bus_wdata;
         end
         set_o = intr && m_pend && !clr_p;
         if (intr) m_pend = 1;
         else if (clr_p) m_pend = 0;
         if (set_o) m_ovr = 1;
         else if (clr_o) m_ovr = 0;
      end
      @(posedge clk);
      #1;
      chk("ack",        32'(bus_ack),       32'(e_ack));
      chk("rdata",      bus_rdata,          e_rd);
      chk("trig_start", 32'(ro_trig_start), 32'(e_st));
      chk("trig_halt",  32'(ro_trig_halt),  32'(e_ht));
      chk("mode",       32'(ro_mode),       32'(m_mode));
      chk("termcount",  ro_termcount,       m_term);
      chk("irq",        32'(irq),           32'(m_pend & m_irq_en));
      obs_rd = bus_rdata;
      reset  = 1'b0;
      rf_int = 1'b0;
   endtask

   function automatic bit pick_int(input int imode);
      if (imode == 2) return ($urandom_range(0, 3) == 0);
      return 1'b0;
   endfunction

   // imode: 0 no rf_int, 1 rf_int on the sampling cycle only, 2 random rf_int every cycle
   task automatic do_access(input bit we, input logic [2:0] a, input logic [31:0] d,
                            input int hold, input int imode, output logic [31:0] rd);
      bus_req = 1'b1; bus_we = we; bus_addr = a; bus_wdata = d;
      step(1, 0, (imode == 1) ? 1'b1 : pick_int(imode));
      rd = obs_rd;
      repeat (hold) step(0, 0, pick_int(imode));
      bus_req = 1'b0; bus_we = 1'($urandom); bus_addr = 3'($urandom); bus_wdata = $urandom;
      step(0, 0, pick_int(imode));
   endtask

   initial begin
      logic [31:0] rd;
      reset = 1'b1; bus_req = 0; bus_we = 0; bus_addr = 0; bus_wdata = 0;
      rf_status = 0; rf_currcount = 0; rf_int = 0;
      m_term = RST_TERM;
      step(0, 1, 0);
      step(0, 1, 1);

      do_access(0, 3'd1, 0, 0, 0, rd);         chk("term_reset", rd, RST_TERM);
      do_access(1, 3'd1, 32'h5, 0, 0, rd);
      do_access(0, 3'd1, 0, 0, 0, rd);         chk("term_read", rd, 32'h5);
      chk("termcount_5", ro_termcount, 32'h5);

      do_access(1, 3'd0, 32'h0000_0103, 0, 0, rd);
      do_access(0, 3'd0, 0, 0, 0, rd);         chk("ctrl_read", rd, 32'h3);
      do_access(1, 3'd0, 32'h0000_0300, 1, 0, rd);
      do_access(1, 3'd0, 32'h0000_0003, 0, 0, rd);

      step(0, 0, 1);
      chk("irq_after_int", 32'(irq), 32'h1);
      step(0, 0, 1);
      do_access(0, 3'd2, 0, 0, 0, rd);         chk("status_6", rd & ~32'h1, 32'h6);
      do_access(1, 3'd2, 32'h6, 0, 0, rd);
      do_access(0, 3'd2, 0, 0, 0, rd);         chk("status_clr", rd & ~32'h1, 32'h0);
      chk("irq_clr", 32'(irq), 32'h0);

      step(0, 0, 1);
      do_access(1, 3'd2, 32'h2, 0, 1, rd);
      chk("irq_set_wins", 32'(irq), 32'h1);
      do_access(0, 3'd2, 0, 0, 0, rd);         chk("status_set_wins", rd & ~32'h1, 32'h2);
      do_access(1, 3'd2, 32'h6, 0, 0, rd);

      do_access(1, 3'd0, 32'h0000_0103, 4, 0, rd);

      // reset in the ACK cycle, then a fresh access while bus_req stays high
      bus_req = 1; bus_we = 1; bus_addr = 3'd0; bus_wdata = 32'h0000_0101;
      step(1, 0, 0);
      step(0, 1, 0);
      chk("rst_ack_irq", 32'(irq), 32'h0);
      step(1, 0, 0);
      bus_req = 0;
      step(0, 0, 0);

      // reset on the sampling edge must not write
      bus_req = 1; bus_we = 1; bus_addr = 3'd1; bus_wdata = 32'h1234_5678;
      step(0, 1, 0);
      bus_req = 0;
      step(0, 0, 0);
      do_access(0, 3'd1, 0, 0, 0, rd);         chk("term_no_write", rd, RST_TERM);

      do_access(1, 3'd5, 32'hFFFF_FFFF, 0, 0, rd);
      do_access(0, 3'd5, 0, 0, 0, rd);         chk("unmapped_read", rd, 32'h0);

      for (int i = 0; i < 400; i++) begin
         logic [31:0] d;
         d = $urandom;
         if ($urandom_range(0, 3) == 0) d[9] = 1'b0;
         if ($urandom_range(0, 39) == 0) begin
            step(0, 1, 1'($urandom));
         end
         do_access(1'($urandom), 3'($urandom_range(0, 7)), d,
                   $urandom_range(0, 3), 2, rd);
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/timer_regs.md
TIMER_REGS -- requirements
Module: timer_regs

Interface
REQ-001 SHALL have parameter RESET_TERM, default 32'h0000_0000, giving the reset value of the TERM register.
REQ-002 SHALL have port clk  input  1  master clock; all logic on its rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port bus_req  input  1  CPU access request, held high until bus_ack is seen.
REQ-005 SHALL have port bus_we  input  1  1 = write, 0 = read; stable while bus_req is high.
REQ-006 SHALL have port bus_addr  input  3  word index of the register.
REQ-007 SHALL have port bus_wdata  input  32  write data.
REQ-008 SHALL have port bus_rdata  output  32  read data, valid only while bus_ack=1, otherwise 0.
REQ-009 SHALL have port bus_ack  output  1  single-cycle access completion.
REQ-010 SHALL have ports ro_trig_start, ro_trig_halt, ro_mode  output  1 each  timer controls.
REQ-011 SHALL have port ro_termcount  output  32  timer terminal count.
REQ-012 SHALL have ports rf_status (input, 1), rf_currcount (input, 32) and rf_int (input, 1-cycle pulse), all from the timer.
REQ-013 SHALL have port irq  output  1  level interrupt to the CPU.

Function
REQ-014 SHALL decode the register map as follows.
- 0 CTRL: bit0 mode RW; bit1 irq_en RW; bit8 start W1-pulse; bit9 halt W1-pulse. Bits 8 and 9 always read 0.
- 1 TERM: RW, 32 bits.
- 2 STATUS: bit0 rf_status RO; bit1 pending W1C; bit2 overrun W1C.
- 3 COUNT: RO rf_currcount.
- 4-7: read 0, writes ignored, still acknowledged.
REQ-015 SHALL implement the bus FSM with states IDLE, ACK and WAIT.
- IDLE + bus_req -> ACK.
- ACK -> WAIT if bus_req is still high; otherwise -> IDLE.
- WAIT -> IDLE when bus_req is low.
REQ-016 SHALL sample the access at the edge that leaves IDLE.
- Register writes take effect at that edge.
- bus_ack=1 and bus_rdata are driven during exactly the following cycle.
- One access per request; no second access until bus_req has been low for at least one cycle.
REQ-017 SHALL capture read data at the sampling edge; COUNT returns the rf_currcount value present in the request cycle.
REQ-018 SHALL drive ro_trig_start or ro_trig_halt high for exactly one cycle, the cycle after the sampling edge of a CTRL write with the corresponding bit set.
REQ-019 SHALL pulse only ro_trig_halt when a CTRL write sets bits 8 and 9 together.
REQ-020 SHALL drive ro_mode from CTRL bit0 and ro_termcount from TERM, both as direct register outputs.
REQ-021 SHALL update interrupt state on a cycle with rf_int=1 as follows.
- Pending set -> 1 at the next edge.
- If pending was already 1 and is not being cleared in the same cycle, overrun -> 1.
REQ-022 SHALL give set priority over clear: when a W1C of pending coincides with rf_int=1, pending remains 1 and overrun is unchanged.
REQ-023 SHALL drive irq = pending AND irq_en (AND of two flops), so irq rises the cycle after rf_int and falls the cycle after a W1C or after irq_en is cleared.
REQ-024 SHALL keep pending and overrun independent of irq_en; they are set even when irq_en=0.

Reset
REQ-025 SHALL, while reset=1, return to the following state at the next edge.
- FSM to IDLE; bus_ack, bus_rdata, ro_trig_start, ro_trig_halt, ro_mode, irq_en, pending, overrun and irq to 0.
- TERM to RESET_TERM.
REQ-026 SHALL abandon an access in progress on reset mid-access: no ack, no write effect, no trigger pulse.
- The bus master re-requests; with bus_req still high after reset, a fresh access starts from IDLE.
REQ-027 SHALL ignore rf_int during the reset cycle.

Structure
REQ-028 SHALL place register word indices (CTRL=0, TERM=1, STATUS=2, COUNT=3) and the CTRL/STATUS bit positions in shared package timer_regs_pkg.
REQ-029 SHALL place the pending/overrun/irq logic in one sub-module, timer_irq_latch; the bus FSM and register file stay in timer_regs.

Verification
REQ-030 SHALL pass: write TERM=32'h0000_0005, then read TERM -> bus_ack one cycle after each request, read data 32'h5, ro_termcount=5.
REQ-031 SHALL pass: write CTRL=32'h0000_0103 -> ro_mode=1, irq_en=1, ro_trig_start high exactly one cycle; CTRL read returns 32'h3.
REQ-032 SHALL pass: write CTRL=32'h0000_0300 -> ro_trig_halt pulses once, ro_trig_start stays 0.
REQ-033 SHALL pass: rf_int pulse with irq_en=1 -> pending=1 and irq=1 the next cycle; second rf_int -> STATUS reads 32'h6; write STATUS=32'h6 -> STATUS reads 0, irq=0.
REQ-034 SHALL pass: W1C of pending in the same cycle as rf_int -> pending stays 1, irq stays 1.
REQ-035 SHALL pass: bus_req held high for 5 cycles on a CTRL start write -> exactly one bus_ack and one ro_trig_start; reset asserted in ACK -> bus_ack=0 on the next cycle and all outputs 0.
